rx_word_sequencer: RTL and testbench

Controller between the UART receiver and the compute datapath. It takes the byte stream (`dato`/`rx_flat`) and assembles it into little-endian 64-bit words. It groups those words into fixed-length frames and presents them downstream over a valid/ready handshake. It also enforces an inter-byte timeout that resynchronises framing, and records words dropped under backpressure.

---
 rtl/rx_word_sequencer.sv | 107 ++++++++++
 tb/tb_rx_word_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_sequencer.sv
// Assembles a UART byte stream into little-endian 64-bit words, tags frame boundaries,
// and hands words downstream over a valid/ready register with inter-byte timeout resync.
module rx_word_sequencer #(
    parameter int WORDS_PER_FRAME = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dato,
    input  logic        rx_flat,
    input  logic        abort,
    input  logic        word_ready,
    output logic [63:0] word_data,
    output logic        word_valid,
    output logic        word_last,
    output logic        overflow,
    output logic        timeout,
    output logic        busy,
    output logic        state_dbg
);

    localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Handshake: a word moves downstream on every rising edge where word_valid and
    // word_ready are both 1; word_data/word_last hold steady while valid waits on ready.
    state_t           state;
    logic [2:0]       byte_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [TO_W-1:0]  to_cnt;
    logic [63:0]      asm_q;
    logic [63:0]      full_word;
    logic             out_free;

    // The 8th byte goes straight into the output register, bypassing the assembly slot.
    assign full_word = {dato, asm_q[55:0]};
    assign out_free  = !word_valid || word_ready;
    assign busy      = (state == COLLECT) || word_valid;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_idx   <= '0;
            to_cnt     <= '0;
            asm_q      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_idx   <= '0;
            to_cnt     <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (rx_flat) begin
                to_cnt <= '0;
                asm_q[{byte_cnt, 3'b000} +: 8] <= dato;
                if (byte_cnt == 3'd7) begin
                    state    <= IDLE;
                    byte_cnt <= '0;
                    word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
                    if (out_free) begin
                        word_data  <= full_word;
                        word_last  <= (word_idx == LAST_IDX);
                        word_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    state    <= COLLECT;
                    byte_cnt <= byte_cnt + 3'd1;
                end
            end else if (state == COLLECT) begin
                // Stalled partial word: drop it and realign to the start of a frame.
                if (to_cnt == TO_LAST) begin
                    state    <= IDLE;
                    byte_cnt <= '0;
                    word_idx <= '0;
                    to_cnt   <= '0;
                    timeout  <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_word_sequencer.sv
// Directed bench for rx_word_sequencer: cycle vector table plus hand-written multi-cycle
// sequences, with a handshake scoreboard checking every delivered word in order.
module tb_rx_word_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  dato;
    logic        rx_flat;
    logic        abort;
    logic        word_ready;
    logic [63:0] word_data;
    logic        word_valid;
    logic        word_last;
    logic        overflow;
    logic        timeout;
    logic        busy;
    logic        state_dbg;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    int to_pulses = 0;
    logic [64:0] exp_q[$];

    rx_word_sequencer #(.WORDS_PER_FRAME(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .dato(dato), .rx_flat(rx_flat), .abort(abort),
        .word_ready(word_ready), .word_data(word_data), .word_valid(word_valid),
        .word_last(word_last), .overflow(overflow), .timeout(timeout), .busy(busy),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: a transfer happens at the next rising edge when valid and ready are high now.
    always @(negedge clk) begin
        if (!rst) begin
            if (timeout) to_pulses++;
            if (word_valid && word_ready) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h last=%0b, expected no word", word_data, word_last);
                end else if ({word_last, word_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_word: got last=%0b %h expected last=%0b %h",
                             word_last, word_data, exp_q[0][64], exp_q[0][63:0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drivers change inputs 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        dato    = b;
        rx_flat = 1'b1;
        @(posedge clk); #1;
        rx_flat = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    typedef struct {
        logic        rx_flat;
        logic [7:0]  dato;
        logic        ready;
        logic        abort;
        logic [4:0]  exp_flags;  // {valid, last, overflow, timeout, busy}
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [63:0] w;
        int          base;

        rst = 1'b1; dato = '0; rx_flat = 1'b0; abort = 1'b0; word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {59'd0, word_valid, word_last, overflow, timeout, busy}, 64'd0);
        check("reset_data", word_data, 64'd0);
        rst = 1'b0;

        // Single word, then abort dropping a simultaneous byte.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 8'(i + 1), 1'b1, 1'b0, (i == 7) ? 5'b10001 : 5'b00001,
                        64'h0807060504030201};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'b00000, 64'h0};
        vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 5'b00000, 64'h0};
        vecs[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 5'b00001, 64'h0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'b00000, 64'h0};
        exp_q.push_back({1'b0, 64'h0807060504030201});
        for (int i = 0; i < 12; i++) begin
            rx_flat = vecs[i].rx_flat; dato = vecs[i].dato;
            word_ready = vecs[i].ready; abort = vecs[i].abort;
            @(posedge clk); #1;
            check($sformatf("vec%0d_flags", i),
                  {59'd0, word_valid, word_last, overflow, timeout, busy},
                  {59'd0, vecs[i].exp_flags});
            if (vecs[i].exp_flags[4]) check($sformatf("vec%0d_data", i), word_data, vecs[i].exp_data);
        end
        rx_flat = 1'b0; abort = 1'b0;

        // Five words: last tag on the 4th, wraps on the 5th.
        base = xfer_cnt;
        word_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom};
            exp_q.push_back({(i == 3), w});
            send_word(w);
        end
        idle(2);
        check("frame_xfers", 64'(xfer_cnt - base), 64'd5);

        // Backpressure: first word held, second dropped, overflow sticky until abort.
        do_abort();
        word_ready = 1'b0;
        exp_q.push_back({1'b0, 64'hA1B2C3D4E5F60718});
        send_word(64'hA1B2C3D4E5F60718);
        check("bp_first_valid", {63'd0, word_valid}, 64'd1);
        send_word(64'h1122334455667788);
        check("bp_held_data", word_data, 64'hA1B2C3D4E5F60718);
        check("bp_flags", {60'd0, word_valid, word_last, overflow, busy}, 64'b1011);
        base = xfer_cnt;
        word_ready = 1'b1;
        idle(1);
        check("bp_drained", {63'd0, word_valid}, 64'd0);
        idle(3);
        check("bp_single_xfer", 64'(xfer_cnt - base), 64'd1);
        check("bp_overflow_sticky", {63'd0, overflow}, 64'd1);
        do_abort();
        check("bp_overflow_cleared", {63'd0, overflow}, 64'd0);

        // Timeout after 3 bytes, with word index already at 1.
        exp_q.push_back({1'b0, 64'h0F0E0D0C0B0A0908});
        send_word(64'h0F0E0D0C0B0A0908);
        idle(2);
        base = to_pulses;
        send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2);
        idle(15);
        check("to_before_threshold", {62'd0, timeout, busy}, 64'b01);
        idle(1);
        check("to_pulse", {62'd0, timeout, busy}, 64'b10);
        idle(1);
        check("to_pulse_width", {63'd0, timeout}, 64'd0);
        check("to_pulse_count", 64'(to_pulses - base), 64'd1);
        for (int i = 0; i < 4; i++) begin
            w = 64'hA7A6A5A4A3A2A1A0 + {8{8'(i * 16)}};
            exp_q.push_back({(i == 3), w});
            send_word(w);
            if (i == 0) check("to_next_word", word_data, 64'hA7A6A5A4A3A2A1A0);
        end
        idle(2);

        // Byte on the threshold cycle suppresses the timeout.
        base = to_pulses;
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
        idle(15);
        send_byte(8'hC3);
        check("thr_busy", {63'd0, busy}, 64'd1);
        exp_q.push_back({1'b0, 64'hC7C6C5C4C3C2C1C0});
        send_byte(8'hC4); send_byte(8'hC5); send_byte(8'hC6); send_byte(8'hC7);
        idle(20);
        check("thr_no_timeout", 64'(to_pulses - base), 64'd0);

        // Transfer and completion on the same edge: no bubble.
        do_abort();
        word_ready = 1'b0;
        exp_q.push_back({1'b0, 64'h2827262524232221});
        send_word(64'h2827262524232221);
        for (int k = 0; k < 7; k++) send_byte(8'h31 + 8'(k));
        exp_q.push_back({1'b0, 64'h3837363534333231});
        word_ready = 1'b1;
        send_byte(8'h38);
        check("nb_valid", {62'd0, word_valid, overflow}, 64'b10);
        check("nb_data", word_data, 64'h3837363534333231);
        idle(1);
        check("nb_drained", {63'd0, word_valid}, 64'd0);

        // Asynchronous reset mid-handshake and mid-word.
        word_ready = 1'b0;
        send_word(64'h5A5A5A5A5A5A5A5A);
        for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k));
        #2 rst = 1'b1;
        #1;
        check("arst_flags", {59'd0, word_valid, word_last, overflow, timeout, busy}, 64'd0);
        check("arst_data", word_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        word_ready = 1'b1;
        exp_q.push_back({1'b0, 64'h1817161514131211});
        for (int k = 0; k < 8; k++) send_byte(8'h11 + 8'(k));
        check("arst_word", word_data, 64'h1817161514131211);
        idle(3);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
